// File: rtl/bus_response_mux.sv
// Response mux: captures the slave select per request and returns the selected slave's read data with a one-cycle completion.
// Latency: master_ready no earlier than 2 clocks after req_valid. Single outstanding transaction; req_valid while busy is dropped.
// RESP_TIMEOUT_EN: ends a WAIT with master_err after TIMEOUT_CYCLES cycles that see no selected ready.
module bus_response_mux #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        slave_output_sel,
    input  logic [DATA_W-1:0] slave_rdata0,
    input  logic [DATA_W-1:0] slave_rdata1,
    input  logic [DATA_W-1:0] slave_rdata2,
    input  logic [DATA_W-1:0] slave_rdata3,
    input  logic [3:0]        slave_ready,
    output logic [DATA_W-1:0] master_rdata,
    output logic              master_ready,
    output logic              master_err,
    output logic              busy,
    output logic [1:0]        active_sel
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_param_chk
        $error("bus_response_mux: TIMEOUT_CYCLES must be 1..255 and below 2**CNT_W");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic                wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdy_q, rdy_d;
    logic                sel_rdy;
    logic [DATA_W-1:0]   sel_rdata;

`ifdef RESP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic err_q, err_d;
`endif

    assign sel_rdy = slave_ready[sel_q];

    always_comb begin
        sel_rdata = slave_rdata0;
        case (sel_q)
            2'd0:    sel_rdata = slave_rdata0;
            2'd1:    sel_rdata = slave_rdata1;
            2'd2:    sel_rdata = slave_rdata2;
            default: sel_rdata = slave_rdata3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
`ifdef RESP_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    sel_d   = slave_output_sel;
                    wr_d    = req_write;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Selected ready is checked first so it beats a timeout in the same cycle.
                if (sel_rdy) begin
                    rdata_d = wr_q ? '0 : sel_rdata;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
`ifdef RESP_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
`endif
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef RESP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign master_err = err_q;
`else
    assign master_err = 1'b0;
`endif

    assign master_rdata = rdata_q;
    assign master_ready = rdy_q;
    assign busy         = (state_q == ST_WAIT);
    assign active_sel   = sel_q;

endmodule

// File: tb/tb_bus_response_mux.sv
// Directed bench for bus_response_mux: linear steps with hand-computed expectations.
module tb_bus_response_mux;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_write;
    logic [1:0]    slave_output_sel;
    logic [DW-1:0] slave_rdata0, slave_rdata1, slave_rdata2, slave_rdata3;
    logic [3:0]    slave_ready;
    logic [DW-1:0] master_rdata;
    logic          master_ready;
    logic          master_err;
    logic          busy;
    logic [1:0]    active_sel;

    int vectors     = 0;
    int miscompares = 0;

    bus_response_mux #(.DATA_W(DW), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .slave_output_sel (slave_output_sel),
        .slave_rdata0     (slave_rdata0),
        .slave_rdata1     (slave_rdata1),
        .slave_rdata2     (slave_rdata2),
        .slave_rdata3     (slave_rdata3),
        .slave_ready      (slave_ready),
        .master_rdata     (master_rdata),
        .master_ready     (master_ready),
        .master_err       (master_err),
        .busy             (busy),
        .active_sel       (active_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [DW-1:0] rd, input logic rdy,
                           input logic err, input logic bsy, input logic [1:0] sel);
        chk({tag, ".rdata"}, master_rdata, rd);
        chk({tag, ".ready"}, {31'd0, master_ready}, {31'd0, rdy});
        chk({tag, ".err"},   {31'd0, master_err},   {31'd0, err});
        chk({tag, ".busy"},  {31'd0, busy},         {31'd0, bsy});
        chk({tag, ".sel"},   {30'd0, active_sel},   {30'd0, sel});
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        slave_output_sel = 2'd0;
        slave_rdata0 = 32'h1111_0000;
        slave_rdata1 = 32'h2222_0001;
        slave_rdata2 = 32'h3333_0002;
        slave_rdata3 = 32'h4444_0003;
        slave_ready = 4'b0000;
        #3;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all("post_reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Read from slave 2, ready three cycles after the capture.
        req_valid = 1'b1; slave_output_sel = 2'd2;
        step();
        req_valid = 1'b0; slave_output_sel = 2'd0;
        chk_all("rd2_cap", 32'h0, 1'b0, 1'b0, 1'b1, 2'd2);
        step();
        step();
        chk("rd2_wait.ready", {31'd0, master_ready}, 32'd0);
        slave_ready = 4'b0100; slave_rdata2 = 32'hA5A5_0002;
        step();
        slave_ready = 4'b0000;
        chk_all("rd2_done", 32'hA5A5_0002, 1'b1, 1'b0, 1'b0, 2'd2);
        step();
        chk_all("rd2_hold", 32'hA5A5_0002, 1'b0, 1'b0, 1'b0, 2'd2);

        // Read from slave 1 while other slaves assert ready; a request while busy is dropped.
        req_valid = 1'b1; slave_output_sel = 2'd1;
        step();
        req_valid = 1'b0;
        slave_ready = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; slave_output_sel = 2'd3;
            end else begin
                req_valid = 1'b0;
            end
            step();
            chk("rd1_ign.ready", {31'd0, master_ready}, 32'd0);
            chk("rd1_ign.busy",  {31'd0, busy}, 32'd1);
        end
        req_valid = 1'b0;
        chk("rd1_busy_req.sel", {30'd0, active_sel}, 32'd1);
        slave_ready = 4'b0010; slave_rdata1 = 32'h1234_5678;
        step();
        slave_ready = 4'b0000;
        chk_all("rd1_done", 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2'd1);

        // Write to slave 3, then a back-to-back read of slave 0 in the pulse cycle.
        step();
        req_valid = 1'b1; req_write = 1'b1; slave_output_sel = 2'd3; slave_rdata3 = 32'hDEAD_BEEF;
        step();
        req_valid = 1'b0; req_write = 1'b0;
        chk_all("wr3_cap", 32'h1234_5678, 1'b0, 1'b0, 1'b1, 2'd3);
        step();
        slave_ready = 4'b1000;
        step();
        slave_ready = 4'b0000;
        chk_all("wr3_done", 32'h0, 1'b1, 1'b0, 1'b0, 2'd3);
        req_valid = 1'b1; slave_output_sel = 2'd0;
        step();
        req_valid = 1'b0;
        chk_all("b2b_cap", 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);
        slave_ready = 4'b0001; slave_rdata0 = 32'hCAFE_0000;
        step();
        slave_ready = 4'b0000;
        chk_all("b2b_done", 32'hCAFE_0000, 1'b1, 1'b0, 1'b0, 2'd0);

`ifdef RESP_TIMEOUT_EN
        // No ready: timeout pulse 16 cycles after entering WAIT; late ready ignored.
        step();
        req_valid = 1'b1; slave_output_sel = 2'd2;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_wait.ready", {31'd0, master_ready}, 32'd0);
        end
        step();
        chk_all("to_fire", 32'h0, 1'b1, 1'b1, 1'b0, 2'd2);
        slave_ready = 4'b0100;
        step();
        slave_ready = 4'b0000;
        chk_all("to_late", 32'h0, 1'b0, 1'b0, 1'b0, 2'd2);

        // Selected ready exactly in the expiry cycle completes normally.
        req_valid = 1'b1; slave_output_sel = 2'd1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("race_pre.ready", {31'd0, master_ready}, 32'd0);
        slave_ready = 4'b0010; slave_rdata1 = 32'h0000_0077;
        step();
        slave_ready = 4'b0000;
        chk_all("race_done", 32'h0000_0077, 1'b1, 1'b0, 1'b0, 2'd1);
`else
        // Without the timeout a WAIT persists until the selected ready.
        step();
        req_valid = 1'b1; slave_output_sel = 2'd2;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk_all("nto_wait", 32'hCAFE_0000, 1'b0, 1'b0, 1'b1, 2'd2);
        slave_ready = 4'b0100; slave_rdata2 = 32'h0000_0077;
        step();
        slave_ready = 4'b0000;
        chk_all("nto_done", 32'h0000_0077, 1'b1, 1'b0, 1'b0, 2'd2);
`endif

        // Reset mid-WAIT clears everything asynchronously; no completion afterwards.
        step();
        req_valid = 1'b1; slave_output_sel = 2'd3;
        step();
        req_valid = 1'b0;
        chk("rst_pre.busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        slave_ready = 4'b1000;
        #1;
        chk_all("rst_async", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk_all("rst_after", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        slave_ready = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_response_mux.md
Name: bus_response_mux

Overview:
- Downstream companion of the address decoder on the unidirectional bus.
- On a master request it captures the decoder's 2-bit slave select and holds it for the data phase.
- It waits for the selected slave's ready, registers that slave's read data back to the master, and pulses a one-cycle completion.
- Provides single-outstanding-transaction tracking and an optional response timeout.

Parameters:
- DATA_W, 32, width of slave/master read data.
- TIMEOUT_CYCLES, 16, WAIT cycles before a timeout error is flagged; only used with RESP_TIMEOUT_EN; legal range 1..255.
- CNT_W, 8, width of the wait counter; TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  master address phase valid (one cycle)
- req_write  input  1  1 = write transaction, 0 = read
- slave_output_sel  input  2  slave index from the address decoder, valid with req_valid
- slave_rdata0  input  DATA_W  read data, slave 0
- slave_rdata1  input  DATA_W  read data, slave 1
- slave_rdata2  input  DATA_W  read data, slave 2
- slave_rdata3  input  DATA_W  read data, slave 3
- slave_ready  input  4  per-slave completion, one bit per slave
- master_rdata  output  DATA_W  registered returned read data
- master_ready  output  1  one-cycle completion pulse
- master_err  output  1  error qualifier, valid only with master_ready
- busy  output  1  transaction outstanding
- active_sel  output  2  captured slave index, held through the data phase

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - state = IDLE.
  - master_rdata = 0, master_ready = 0, master_err = 0, busy = 0, active_sel = 0.
  - Wait counter = 0.
  - Reset mid-transaction abandons it with no completion pulse.
- FSM states: IDLE and WAIT.
- IDLE:
  - req_valid = 1 → capture slave_output_sel into active_sel and req_write into an internal write flag, clear counter, busy = 1, go to WAIT next cycle.
  - The earliest completion is the cycle after entering WAIT, so minimum request-to-master_ready latency is 2 clocks.
- WAIT:
  - Only slave_ready[active_sel] is observed; ready from other slaves is ignored.
  - On selected ready:
    - master_rdata <= 0 for a write, else slave_rdataN[active_sel].
    - master_ready = 1 for exactly one cycle, master_err = 0.
    - busy = 0, go to IDLE.
  - Otherwise the counter increments, saturating at 2^CNT_W-1.
- req_valid while busy: ignored; captured state unchanged. Masters must not issue while busy.
- Back-to-back: a req_valid in the same cycle master_ready pulses (state now IDLE) is accepted.
- master_rdata holds its last value between completions.
- master_err is 0 whenever master_ready is 0.
- active_sel holds its value after completion until the next capture.

Optional Feature:
- Macro: RESP_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT_CYCLES-1 with no selected ready, the next edge gives master_ready = 1, master_err = 1, master_rdata = 0, busy = 0, go to IDLE.
  - Selected ready in the same cycle as expiry wins: normal completion, err = 0.
  - A late slave ready after timeout is ignored.
- Undefined: WAIT persists indefinitely; master_err is tied to 0; no timeout logic is compiled.

Test Plan:
- Reset with rst_n = 0 mid-WAIT → all outputs 0 immediately (asynchronous); no master_ready after release.
- Read, sel = 2; slave_ready = 4'b0100 with rdata2 = 32'hA5A5_0002 three cycles later → master_ready one cycle with master_rdata = 32'hA5A5_0002, err = 0, busy falls.
- Read, sel = 1; slave_ready = 4'b1001 for 5 cycles, then 4'b0010 with rdata1 = 32'h1234_5678 → ignored until bit 1, then rdata = 32'h1234_5678.
- Write, sel = 3; slave_ready[3] after 1 cycle → master_ready with rdata = 0; a second req_valid in the pulse cycle, sel = 0, is accepted (busy = 1 next cycle, active_sel = 0).
- RESP_TIMEOUT_EN, TIMEOUT_CYCLES = 16; read with no ready → master_ready and master_err pulse 16 cycles after entering WAIT, rdata = 0; a later slave_ready is ignored.
- RESP_TIMEOUT_EN; selected ready asserted exactly in the expiry cycle → err = 0 with valid data.
